// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/subtract scheduler.
package wide_add_pkg;
  localparam int WORD_W = 32;
  localparam int NREQ   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic req_id_t;
endpackage

// File: rtl/carry_lookahead_adder.sv
// 32-bit combinational adder built from 4-bit lookahead groups.
// Group carries are rippled between the groups.
module carry_lookahead_adder
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  localparam int NGRP = WORD_W / 4;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W:0]   c;
  logic [NGRP-1:0]   grp_g;
  logic [NGRP-1:0]   grp_p;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    c[0]  = cin;
    for (int k = 0; k < NGRP; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
      // The group carry-out skips the in-group chain.
      c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
    end
    sum  = p ^ c[WORD_W-1:0];
    cout = c[WORD_W];
  end
endmodule

// File: rtl/wide_add_scheduler.sv
// Shares one 32-bit adder between two requesters issuing NWORDS-word add/sub
// operations, LS word first, with a registered carry chain and result stream.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// BUSY  | granted requester streams words through the adder
module wide_add_scheduler
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   rq_valid,
  output logic [NREQ-1:0]   rq_ready,
  input  logic [NREQ-1:0]   rq_sub,
  input  logic [WORD_W-1:0] rq0_a,
  input  logic [WORD_W-1:0] rq0_b,
  input  logic [WORD_W-1:0] rq1_a,
  input  logic [WORD_W-1:0] rq1_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_sum,
  output logic              res_id,
  output logic              res_last,
  output logic              res_cout
);
  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  state_t            state;
  state_t            state_nxt;
  req_id_t           grant;
  req_id_t           rr_ptr;
  req_id_t           winner;
  logic              sub_q;
  logic              carry_q;
  logic [CNT_W-1:0]  wcnt;
  logic              accept;
  logic              first;
  logic              last;
  logic              sub_eff;
  logic              add_cin;
  logic              add_cout;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] add_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|rq_valid) state_nxt = BUSY;
      BUSY:    if (accept && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rq_ready = '0;
    if (state == BUSY) rq_ready[grant] = !res_valid | res_ready;
  end

  always_comb begin
    if (rq_valid[0] & rq_valid[1]) winner = rr_ptr;
    else                           winner = rq_valid[1];
  end

  assign accept  = rq_valid[grant] & rq_ready[grant];
  assign first   = (wcnt == '0);
  assign last    = (wcnt == LAST_IDX);
  // Op select is only honoured on word 0; later words reuse the latched value.
  assign sub_eff = first ? rq_sub[grant] : sub_q;
  assign add_cin = first ? sub_eff : carry_q;
  assign op_a    = grant ? rq1_a : rq0_a;
  assign op_b    = (grant ? rq1_b : rq0_b) ^ {WORD_W{sub_eff}};

  carry_lookahead_adder u_cla (
    .a    (op_a),
    .b    (op_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= 1'b0;
      rr_ptr  <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      wcnt    <= '0;
    end else begin
      if (state == IDLE && |rq_valid) grant <= winner;
      if (accept) begin
        if (first) sub_q <= sub_eff;
        if (last) begin
          carry_q <= 1'b0;
          wcnt    <= '0;
          rr_ptr  <= ~grant;
        end else begin
          carry_q <= add_cout;
          wcnt    <= wcnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= 1'b0;
      res_last  <= 1'b0;
      res_cout  <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_sum   <= add_sum;
      res_id    <= grant;
      res_last  <= last;
      res_cout  <= add_cout;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wide_add_scheduler.sv
// Directed bench for wide_add_scheduler (NWORDS=4): add, subtract, arbitration,
// output back-pressure and asynchronous reset mid-operation.
module tb_wide_add_scheduler;
  localparam int NW = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_ready;
  logic [1:0]  rq_sub;
  logic [31:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_id;
  logic        res_last;
  logic        res_cout;

  int n_tests = 0;
  int n_fail  = 0;

  wide_add_scheduler #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq_sub    (rq_sub),
    .rq0_a     (rq0_a),
    .rq0_b     (rq0_b),
    .rq1_a     (rq1_a),
    .rq1_b     (rq1_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_last  (res_last),
    .res_cout  (res_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic s, input logic [31:0] a, input logic [31:0] b);
    rq_sub[id] = s;
    if (id) begin rq1_a = a; rq1_b = b; end
    else    begin rq0_a = a; rq0_b = b; end
  endtask

  // Streams one operation for requester id; checks each result word one cycle
  // after its accept. Later words carry an inverted op select, which must be ignored.
  task automatic run_op(input logic id, input logic s, input logic [127:0] a,
                        input logic [127:0] b, input logic [127:0] exp,
                        input logic exp_cout, input int stall_w, input int stop_w);
    int   w;
    int   cyc;
    int   waitc;
    logic acc;
    logic [31:0] hold_sum;
    w = 0; cyc = 0; waitc = 0;
    drive(id, s, a[31:0], b[31:0]);
    rq_valid[id] = 1'b1;
    while (w < stop_w && cyc < 40) begin
      #1;
      acc = rq_valid[id] & rq_ready[id];
      chk("other_ready", {31'b0, rq_ready[~id]}, 32'd0);
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (w == 0) chk("first_accept_wait", 32'(waitc), 32'd1);
        chk("res_valid", {31'b0, res_valid}, 32'd1);
        chk("res_sum", res_sum, exp[32*w +: 32]);
        chk("res_id", {31'b0, res_id}, {31'b0, id});
        chk("res_last", {31'b0, res_last}, (w == NW-1) ? 32'd1 : 32'd0);
        if (w == NW-1) chk("res_cout", {31'b0, res_cout}, {31'b0, exp_cout});
        if (w == stall_w) begin
          res_ready = 1'b0;
          hold_sum  = exp[32*w +: 32];
          repeat (3) begin
            #1;
            chk("stall_rq_ready", {31'b0, rq_ready[id]}, 32'd0);
            @(negedge clk);
            chk("stall_valid", {31'b0, res_valid}, 32'd1);
            chk("stall_sum", res_sum, hold_sum);
            chk("stall_id", {31'b0, res_id}, {31'b0, id});
            chk("stall_last", {31'b0, res_last}, 32'd0);
          end
          res_ready = 1'b1;
        end
        w++;
        if (w < NW) drive(id, ~s, a[32*w +: 32], b[32*w +: 32]);
        else        rq_valid[id] = 1'b0;
      end else if (w == 0) begin
        waitc++;
      end
    end
    chk("words_done", 32'(w), 32'(stop_w));
  endtask

  initial begin
    rst_n     = 1'b0;
    rq_valid  = 2'b00;
    rq_sub    = 2'b00;
    rq0_a = '0; rq0_b = '0; rq1_a = '0; rq1_b = '0;
    res_ready = 1'b1;

    #3;
    chk("rst_rq_ready", {30'b0, rq_ready}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_sum", res_sum, 32'd0);
    chk("rst_res_flags", {29'b0, res_id, res_last, res_cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both request together: rq0 first, then rq1 (5-7 with borrow).
    drive(1'b1, 1'b1, 32'h5, 32'h7);
    rq_valid[1] = 1'b1;
    run_op(1'b0, 1'b0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1,
           128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, -1, NW);
    chk("idle_gap_ready", {30'b0, rq_ready}, 32'd0);
    run_op(1'b1, 1'b1, 128'h5, 128'h7,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, -1, NW);

    // 7-5 on rq1 with a 3-cycle output stall after word 1.
    @(negedge clk);
    run_op(1'b1, 1'b1, 128'h7, 128'h5, 128'h2, 1'b1, 1, NW);

    // Abort rq1 after two words, carry register holding 1.
    @(negedge clk);
    run_op(1'b1, 1'b0, {4{32'hFFFF_FFFF}}, {4{32'h1}},
           128'h0000_0001_0000_0001_0000_0001_0000_0000, 1'b1, -1, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("arst_res_sum", res_sum, 32'd0);
    chk("arst_flags", {29'b0, res_id, res_last, res_cout}, 32'd0);
    chk("arst_rq_ready", {30'b0, rq_ready}, 32'd0);
    rq_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh op after reset: no stale carry or word count.
    run_op(1'b0, 1'b0, 128'h5, 128'h7, 128'hC, 1'b0, -1, NW);
    @(negedge clk);
    chk("drain_res_valid", {31'b0, res_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wide_add_scheduler.md
# wide_add_scheduler

Sequences and shares the team's 32-bit `carry_lookahead_adder` between two requesters, each issuing multi-word (NWORDS × 32-bit) add or subtract operations streamed least-significant word first. A round-robin arbiter grants one requester for a whole operation. The block chains the carry between words through a register and returns a registered, valid/ready result stream tagged with the requester ID. It sits between client engines and the single shared adder datapath.

## Interface
- NWORDS, 4: words per operation; legal 1..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rq_valid  in  2  per-requester word valid.
- rq_ready  out  2  per-requester word accept.
- rq_sub  in  2  per-requester op select (1 = subtract); sampled on the first word only.
- rq0_a, rq0_b  in  32 each  requester 0 operand words.
- rq1_a, rq1_b  in  32 each  requester 1 operand words.
- res_valid  out  1  result word valid.
- res_ready  in  1  result word accept.
- res_sum  out  32  result word.
- res_id  out  1  owning requester.
- res_last  out  1  final word of the operation.
- res_cout  out  1  final carry, meaningful only when res_last=1; for subtract, 1 = no borrow.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - rq_ready=0.
  - If any rq_valid: register grant = round-robin winner and go to BUSY.
  - When both request, grant = rr_ptr; rr_ptr resets to 0.
- BUSY:
  - rq_ready[grant] = (!res_valid | res_ready); the other requester's ready = 0.
  - A word is accepted on rq_valid[grant] & rq_ready[grant].
- Word 0: latch sub = rq_sub[grant]; adder cin = sub.
- Words 1..NWORDS-1: adder cin = carry register.
- Adder operands: a, and b ^ {32{sub}}. Every accept loads the carry register with adder cout.
- Word counter increments per accept.
- On accept of word NWORDS-1:
  - set res_last;
  - go to IDLE;
  - rr_ptr = ~grant;
  - clear the word counter and carry register.
- If the granted requester drops rq_valid mid-operation, hold BUSY indefinitely with no timeout. Other requesters stay blocked.
- rq_sub on non-first words is ignored.
- Sum is modulo 2^(32·NWORDS); overflow is reported only via res_cout.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant=0, carry=0, counter=0, rq_ready=0, res_valid=0, res_sum=0, res_id=0, res_last=0, res_cout=0.
- Arbitration costs one bubble: rq_valid seen in IDLE gives the earliest accept in the next cycle.
- Latency: 1 cycle from word accept to res_valid with that word.
- Throughput: 1 word/cycle while res_ready=1.
- Output register:
  - loads on accept;
  - res_valid clears when res_ready=1 and no new accept occurs;
  - holds all fields stable while res_valid & !res_ready.
- Back-to-back operations:
  - after the last word, the next grant takes one IDLE cycle;
  - res_valid of the last word may overlap that IDLE cycle.
- Asynchronous reset mid-operation: all state returns to reset values immediately. A partial result is discarded and never completed.

## Structure
- Package wide_add_pkg holds:
  - WORD_W=32;
  - NREQ=2;
  - the state enum type (IDLE, BUSY);
  - the requester ID typedef.
- One sub-module: carry_lookahead_adder (32-bit, instantiated once, purely combinational). All sequencing, arbitration and registers stay in wide_add_scheduler.

## Test plan
- NWORDS=4, rq0 adds A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF + B=1 -> words 0x0,0x0,0x1,0x0, res_id=0, res_last on word 3, res_cout=0.
- rq1 subtracts 5−7 (words 0x5/0x7, upper words 0) -> all words 0xFFFF_FFFE then 0xFFFF_FFFF…, res_cout=0 (borrow). Then 7−5 -> 0x2,0,0,0 with res_cout=1.
- Both rq_valid raised the same cycle after reset -> rq0 served first. Then rq1 is granted with exactly one IDLE cycle between, and rq1 never gets ready during rq0's operation.
- res_ready held low 3 cycles mid-stream -> rq_ready low, res_sum/res_id/res_last stable, carry chain still correct after release.
- rst_n asserted after word 2 of 4 -> outputs return to reset values asynchronously. The next operation's word 0 uses cin=sub, with no stale carry.
